mem_port_arbiter: RTL and testbench

- Shares the single-port `memory` block (`clock`, `wEn`, 16-bit `address`, 32-bit `write_data`/`read_data`) between two requesters.
- Requester 1 is the instruction-fetch port (read-only). Requester 2 is the load/store data port (read/write).
- Sits between the core pipeline and `main_memory`. It arbitrates, drives the memory pins and returns read data with a valid strobe.
- One transaction is in flight at a time.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_picker.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the two-requester memory port arbiter.
// Imported by mem_arb_picker and mem_port_arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   // Wide enough for the legal MEM_LATENCY range of 1..3.
   localparam int LAT_W = 2;

   typedef enum logic {
      IDLE      = 1'b0,
      READ_WAIT = 1'b1
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   function automatic owner_t other_owner(input owner_t own);
      return (own == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
   endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select between the fetch and data requesters.
// Build option MEM_ARB_ROUND_ROBIN_EN swaps fixed data-first priority for a last-grant flag.
module mem_arb_picker
   import mem_arb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic if_req,
   input  logic d_req,
   output logic if_win,
   output logic d_win
);

   owner_t winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t last_gnt;

   always_comb begin
      if (if_req && d_req) begin
         winner = other_owner(last_gnt);
      end else if (d_req) begin
         winner = OWN_DATA;
      end else begin
         winner = OWN_FETCH;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_gnt <= OWN_FETCH;
      end else if (enable && (if_req || d_req)) begin
         last_gnt <= winner;
      end
   end
`else
   // Fixed priority needs no state; clock and reset are deliberately left idle.
   logic unused_seq;
   assign unused_seq = clock & reset;
   assign winner     = d_req ? OWN_DATA : OWN_FETCH;
`endif

   assign d_win  = enable && d_req  && (winner == OWN_DATA);
   assign if_win = enable && if_req && (winner == OWN_FETCH);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a read-only fetch port and a read/write data port.
// One read in flight at a time; define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MEM_LATENCY = 1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_wEn,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_t            state;
   owner_t            owner;
   logic [LAT_W-1:0]  lat_cnt;
   logic [ADDR_W-1:0] addr_q;

   logic enable;
   logic if_win;
   logic d_win;
   logic d_write;
   logic rd_start;

   // Grants are gated by reset so every output reads 0 while reset is held.
   assign enable = (state == IDLE) && reset;

   mem_arb_picker u_picker (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .if_req (if_req),
      .d_req  (d_req),
      .if_win (if_win),
      .d_win  (d_win)
   );

   assign if_gnt   = if_win;
   assign d_gnt    = d_win;
   assign d_write  = d_win && d_we;
   assign rd_start = if_win || (d_win && !d_we);

   // NOTE: every branch assigns mem_address, so always_comb infers no latch.
   always_comb begin
      if (if_win) begin
         mem_address = if_addr;
      end else if (d_win) begin
         mem_address = d_addr;
      end else begin
         mem_address = addr_q;
      end
   end

   assign mem_wEn        = d_write;
   assign mem_write_data = d_write ? d_wdata : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= OWN_FETCH;
         lat_cnt   <= '0;
         addr_q    <= '0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         // NOTE: the rdata holding registers are plain flops, so they are reset to a known 0.
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every read here on the pre-edge values.
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         case (state)
            IDLE: begin
               if (if_win || d_win) begin
                  addr_q <= mem_address;
               end
               if (rd_start) begin
                  owner   <= d_win ? OWN_DATA : OWN_FETCH;
                  lat_cnt <= LAT_W'(MEM_LATENCY);
                  state   <= READ_WAIT;
               end
            end
            READ_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == LAT_W'(1)) begin
                  if (owner == OWN_DATA) begin
                     d_rdata  <= mem_read_data;
                     d_rvalid <= 1'b1;
                  end else begin
                     if_rdata  <= mem_read_data;
                     if_rvalid <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a latency-1 instance with a memory model and a
// latency-3 instance for the top-of-address fetch; read data checked through per-port queues.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wEn;
   logic [DW-1:0] if_rdata, d_rdata, mem_write_data, mem_read_data;
   logic [AW-1:0] mem_address;

   logic          if_req3;
   logic [AW-1:0] if_addr3;
   logic          if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_wEn3;
   logic [DW-1:0] if_rdata3, d_rdata3, mem_write_data3, mem_read_data3;
   logic [AW-1:0] mem_address3;

   logic [DW-1:0] wmem [0:15];
   logic [15:0]   wvalid = '0;
   logic [DW-1:0] p0, p1, p2;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] q_if[$], q_d[$], q_if3[$];
   logic [DW-1:0] exp_if, exp_d, exp_if3;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_wEn(mem_wEn), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_dut3 (
      .clock(clock), .reset(reset),
      .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
      .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(32'h0000_0000),
      .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_wEn(mem_wEn3), .mem_address(mem_address3), .mem_write_data(mem_write_data3),
      .mem_read_data(mem_read_data3)
   );

   // Preloaded contents: word 3 is DEADBEEF, everything else a fixed address pattern.
   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
      if (a == 16'h0003) return 32'hDEAD_BEEF;
      return {a ^ 16'hC3A5, a};
   endfunction

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (a < 16'd16 && wvalid[a[3:0]]) return wmem[a[3:0]];
      return pattern(a);
   endfunction

   always @(posedge clock) begin
      if (mem_wEn && mem_address < 16'd16) begin
         wmem[mem_address[3:0]]   <= mem_write_data;
         wvalid[mem_address[3:0]] <= 1'b1;
      end
      mem_read_data <= mem_rd(mem_address);
      p0 <= mem_rd(mem_address3);
      p1 <= p0;
      p2 <= p1;
   end
   assign mem_read_data3 = p2;

   // Scoreboard side: every rvalid pops the oldest expected word for its port.
   always @(negedge clock) begin
      if (if_rvalid) begin
         checks++;
         if (q_if.size() == 0) begin
            errors++;
            $display("FAIL if_rvalid_unexpected: if_rvalid=1 with no fetch read outstanding");
         end else begin
            exp_if = q_if.pop_front();
            if (if_rdata !== exp_if) begin
               errors++;
               $display("FAIL if_rdata: got %h expected %h", if_rdata, exp_if);
            end
         end
      end
      if (d_rvalid) begin
         checks++;
         if (q_d.size() == 0) begin
            errors++;
            $display("FAIL d_rvalid_unexpected: d_rvalid=1 with no data read outstanding");
         end else begin
            exp_d = q_d.pop_front();
            if (d_rdata !== exp_d) begin
               errors++;
               $display("FAIL d_rdata: got %h expected %h", d_rdata, exp_d);
            end
         end
      end
      if (if_rvalid3) begin
         checks++;
         if (q_if3.size() == 0) begin
            errors++;
            $display("FAIL if_rvalid3_unexpected: if_rvalid3=1 with no fetch read outstanding");
         end else begin
            exp_if3 = q_if3.pop_front();
            if (if_rdata3 !== exp_if3) begin
               errors++;
               $display("FAIL if_rdata3: got %h expected %h", if_rdata3, exp_if3);
            end
         end
      end
      if (d_rvalid3) begin
         checks++;
         errors++;
         $display("FAIL d_rvalid3_unexpected: got 1 expected 0");
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t last_own = OWN_FETCH;
   always begin
      @(negedge clock);
      #2;
      if (!reset)     last_own = OWN_FETCH;
      else if (d_gnt) last_own = OWN_DATA;
      else if (if_gnt) last_own = OWN_FETCH;
   end
`endif

   task automatic wait_drain(output bit drained);
      drained = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         #1;
         if (q_if.size() == 0 && q_d.size() == 0 && q_if3.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      if_req = 1'b1; if_addr = 16'd3;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'd4; d_wdata = 32'hFFFF_FFFF;
      if_req3 = 1'b1; if_addr3 = 16'hFFFF;
      repeat (2) @(negedge clock);
      checks++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wEn} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wEn});
      end
      checks++;
      if (mem_address !== 16'h0 || mem_write_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem_pins: addr=%h wdata=%h expected 0", mem_address, mem_write_data);
      end
      checks++;
      if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h expected 0", if_rdata, d_rdata);
      end
      checks++;
      if ({if_gnt3, d_gnt3, if_rvalid3, d_rvalid3, mem_wEn3, mem_address3, mem_write_data3,
           if_rdata3, d_rdata3} !== '0) begin
         errors++;
         $display("FAIL reset_lat3: outputs of latency-3 instance not all 0");
      end
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; if_req3 = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({if_gnt, d_gnt, mem_wEn} !== 3'b000) begin
         errors++;
         $display("FAIL idle_no_req: got %b expected 000", {if_gnt, d_gnt, mem_wEn});
      end
   endtask

   task automatic test_fetch_read;
      bit ok;
      @(posedge clock);
      #1 if_req = 1'b1; if_addr = 16'd3;
      q_if.push_back(32'hDEAD_BEEF);
      @(negedge clock);
      checks++;
      if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_address !== 16'd3 || mem_wEn !== 1'b0) begin
         errors++;
         $display("FAIL fetch_grant: gnt=%b/%b addr=%h wEn=%b expected 1/0 0003 0", if_gnt, d_gnt, mem_address, mem_wEn);
      end
      @(posedge clock);
      #1 if_req = 1'b0;
      @(negedge clock);
      checks++;
      if (if_rvalid !== 1'b0 || if_gnt !== 1'b0 || mem_address !== 16'd3) begin
         errors++;
         $display("FAIL fetch_wait: rvalid=%b gnt=%b addr=%h expected 0 0 0003", if_rvalid, if_gnt, mem_address);
      end
      @(negedge clock);
      checks++;
      if (if_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL fetch_latency: if_rvalid=%b expected 1 two cycles after grant", if_rvalid);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fetch_drain: %0d reads still outstanding expected 0", q_if.size());
      end
   endtask

   task automatic test_write_then_read;
      bit ok;
      @(posedge clock);
      #1 d_req = 1'b1; d_we = 1'b1; d_addr = 16'd4; d_wdata = 32'd1;
      @(negedge clock);
      checks++;
      if (d_gnt !== 1'b1 || mem_wEn !== 1'b1 || mem_address !== 16'd4 || mem_write_data !== 32'd1) begin
         errors++;
         $display("FAIL write_grant: gnt=%b wEn=%b addr=%h wdata=%h expected 1 1 0004 00000001", d_gnt, mem_wEn, mem_address, mem_write_data);
      end
      @(posedge clock);
      #1 d_we = 1'b0; d_wdata = 32'h0;
      q_d.push_back(32'd1);
      @(negedge clock);
      checks++;
      if (d_gnt !== 1'b1 || mem_wEn !== 1'b0 || d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL read_after_write: gnt=%b wEn=%b rvalid=%b expected 1 0 0", d_gnt, mem_wEn, d_rvalid);
      end
      @(posedge clock);
      #1 d_req = 1'b0;
      @(negedge clock);
      checks++;
      if (d_rvalid !== 1'b0 || mem_wEn !== 1'b0) begin
         errors++;
         $display("FAIL read_wait: rvalid=%b wEn=%b expected 0 0", d_rvalid, mem_wEn);
      end
      @(negedge clock);
      checks++;
      if (d_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL data_read_latency: d_rvalid=%b expected 1", d_rvalid);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL write_read_drain: %0d reads still outstanding expected 0", q_d.size());
      end
   endtask

   task automatic test_simultaneous;
      bit ok, if_pend, d_pend, exp_data;
      for (int p = 0; p < 4; p++) begin
         @(posedge clock);
         #1 if_req = 1'b1; if_addr = 16'd0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd8;
         q_if.push_back(pattern(16'd0));
         q_d.push_back(pattern(16'd8));
         if_pend = 1'b1;
         d_pend  = 1'b1;
         for (int c = 0; c < 20 && (if_pend || d_pend); c++) begin
            @(negedge clock);
            if (if_pend && d_pend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               exp_data = (last_own == OWN_FETCH);
`else
               exp_data = 1'b1;
`endif
            end else begin
               exp_data = d_pend;
            end
            if (if_gnt || d_gnt) begin
               checks++;
               if (d_gnt !== exp_data || if_gnt !== !exp_data) begin
                  errors++;
                  $display("FAIL pick_pair%0d: d_gnt=%b if_gnt=%b expected %b %b", p, d_gnt, if_gnt, exp_data, !exp_data);
               end
               if (d_gnt)  d_pend  = 1'b0;
               if (if_gnt) if_pend = 1'b0;
               @(posedge clock);
               #1;
               if (!d_pend)  d_req  = 1'b0;
               if (!if_pend) if_req = 1'b0;
            end
         end
         checks++;
         if (if_pend || d_pend) begin
            errors++;
            $display("FAIL pair%0d_timeout: pending if=%b d=%b expected 0 0", p, if_pend, d_pend);
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL simultaneous_drain: if=%0d d=%0d outstanding expected 0", q_if.size(), q_d.size());
      end
   endtask

   task automatic test_reset_mid_read;
      bit ok;
      @(posedge clock);
      #1 if_req = 1'b1; if_addr = 16'h0010;
      @(negedge clock);
      checks++;
      if (if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_grant: if_gnt=%b expected 1", if_gnt);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wEn, mem_address, mem_write_data, if_rdata, d_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: gnt=%b/%b rvalid=%b/%b wEn=%b addr=%h rdata=%h/%h expected all 0",
                  if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wEn, mem_address, if_rdata, d_rdata);
      end
      if_req = 1'b0;
      repeat (2) @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_rvalid: cycle %0d rvalid=%b/%b expected 0 0", c, if_rvalid, d_rvalid);
         end
      end
      @(posedge clock);
      #1 if_req = 1'b1; if_addr = 16'h0010;
      q_if.push_back(pattern(16'h0010));
      @(negedge clock);
      checks++;
      if (if_gnt !== 1'b1 || mem_address !== 16'h0010) begin
         errors++;
         $display("FAIL rst_mid_resume: gnt=%b addr=%h expected 1 0010", if_gnt, mem_address);
      end
      @(posedge clock);
      #1 if_req = 1'b0;
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_mid_drain: %0d reads outstanding expected 0", q_if.size());
      end
   endtask

   task automatic test_drop_before_grant;
      bit ok;
      @(posedge clock);
      #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'd8; if_req = 1'b1; if_addr = 16'd5;
      q_d.push_back(pattern(16'd8));
      @(negedge clock);
      checks++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL busy_grant: d_gnt=%b if_gnt=%b expected 1 0", d_gnt, if_gnt);
      end
      @(posedge clock);
      #1 d_req = 1'b0; if_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if (if_gnt !== 1'b0 || mem_wEn !== 1'b0 || mem_address === 16'd5) begin
            errors++;
            $display("FAIL dropped_fetch: cycle %0d if_gnt=%b wEn=%b addr=%h expected 0 0 not-0005", c, if_gnt, mem_wEn, mem_address);
         end
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL dropped_drain: %0d reads outstanding expected 0", q_d.size());
      end
   endtask

   task automatic test_latency3;
      bit ok;
      @(posedge clock);
      #1 if_req3 = 1'b1; if_addr3 = 16'hFFFF;
      q_if3.push_back(pattern(16'hFFFF));
      @(negedge clock);
      checks++;
      if (if_gnt3 !== 1'b1 || mem_address3 !== 16'hFFFF) begin
         errors++;
         $display("FAIL lat3_grant: gnt=%b addr=%h expected 1 ffff", if_gnt3, mem_address3);
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         checks++;
         if (if_gnt3 !== 1'b0 || if_rvalid3 !== 1'b0 || d_gnt3 !== 1'b0 || mem_wEn3 !== 1'b0 || mem_address3 !== 16'hFFFF) begin
            errors++;
            $display("FAIL lat3_wait: cycle %0d gnt=%b rvalid=%b addr=%h expected 0 0 ffff", c, if_gnt3, if_rvalid3, mem_address3);
         end
      end
      @(posedge clock);
      #1 if_req3 = 1'b0;
      @(negedge clock);
      checks++;
      if (if_rvalid3 !== 1'b1) begin
         errors++;
         $display("FAIL lat3_rvalid: if_rvalid3=%b expected 1 four cycles after grant", if_rvalid3);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL lat3_drain: %0d reads outstanding expected 0", q_if3.size());
      end
   endtask

   initial begin
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      if_req3 = 1'b0; if_addr3 = '0;
      test_reset();
      test_fetch_read();
      test_write_then_read();
      test_simultaneous();
      test_reset_mid_read();
      test_drop_before_grant();
      test_latency3();
      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
